// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential Hack-style ALU.
// Holds the FSM state encoding and the default datapath width.
package seq_alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU datapath: operand preprocess, add/and, negate.
// Ports: x, y operands; zx nx zy ny f no controls; x2, y2 preprocessed
// operands; out final result.
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r;

    always_comb begin
        x2 = zx ? '0 : x;
        if (nx) begin
            x2 = ~x2;
        end
        y2 = zy ? '0 : y;
        if (ny) begin
            y2 = ~y2;
        end
        r   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~r : r;
    end

endmodule

// File: rtl/seq_alu.sv
// Hack ALU with an added shift-add multiply behind a valid/ready handshake.
// Ports: clock, reset; in_valid/in_ready with x, y, controls and mul;
// out_valid/out_ready with out and its zr/ng flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MUL_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             no_q, no_d;

    logic             accept;
    logic             mul_eff;
    logic             in_mul;
    logic             step_last;
    logic [WIDTH-1:0] acc_step;

    logic [WIDTH-1:0] core_x, core_y;
    logic [WIDTH-1:0] core_x2, core_y2, core_out;
    logic             core_zx, core_nx, core_zy, core_ny;
    logic             core_f, core_no;

    assign mul_eff   = (MUL_EN != 0) && mul;
    assign in_mul    = (state_q == MUL);
    assign accept    = in_valid && in_ready;
    assign step_last = (cnt_q == LAST);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // During MUL the core passes acc through (y forced to all ones,
    // f=0 gives x&~0) so it only applies the captured no bit.
    always_comb begin
        core_x  = x;
        core_y  = y;
        core_zx = zx;
        core_nx = nx;
        core_zy = zy;
        core_ny = ny;
        core_f  = f;
        core_no = no;
        if (in_mul) begin
            core_x  = acc_step;
            core_zx = 1'b0;
            core_nx = 1'b0;
            core_zy = 1'b1;
            core_ny = 1'b1;
            core_f  = 1'b0;
            core_no = no_q;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x   (core_x),
        .y   (core_y),
        .zx  (core_zx),
        .nx  (core_nx),
        .zy  (core_zy),
        .ny  (core_ny),
        .f   (core_f),
        .no  (core_no),
        .x2  (core_x2),
        .y2  (core_y2),
        .out (core_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            zr_q     <= 1'b1;
            ng_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            no_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            zr_q     <= zr_d;
            ng_q     <= ng_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            no_q     <= no_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = mul_eff ? MUL : DONE;
                end
            end
            MUL: begin
                if (step_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = mul_eff ? MUL : DONE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        zr_d     = zr_q;
        ng_d     = ng_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        no_d     = no_q;
        if (accept) begin
            if (mul_eff) begin
                mcand_d  = core_x2;
                mplier_d = core_y2;
                acc_d    = '0;
                cnt_d    = '0;
                no_d     = no;
            end else begin
                out_d = core_out;
                zr_d  = (core_out == '0);
                ng_d  = core_out[WIDTH-1];
            end
        end else if (in_mul) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (step_last) begin
                out_d = core_out;
                zr_d  = (core_out == '0);
                ng_d  = core_out[WIDTH-1];
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) ||
                    ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        out       = out_q;
        zr        = zr_q;
        ng        = ng_q;
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed requests push expected results,
// a monitor pops and checks them, plus stall, busy and reset checks.
module tb_seq_alu;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zx, nx, zy, ny, f, no, mul;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;

    always #5 clock = ~clock;

    seq_alu #(
        .WIDTH  (W),
        .MUL_EN (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .mul       (mul),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         zr;
        logic         ng;
        int           when;
    } exp_t;

    // control vector order: {zx, nx, zy, ny, f, no, mul}
    localparam logic [6:0] C_ADD  = 7'b0000100;
    localparam logic [6:0] C_AND  = 7'b0000000;
    localparam logic [6:0] C_SUB  = 7'b0100110;
    localparam logic [6:0] C_ZERO = 7'b1010100;
    localparam logic [6:0] C_MUL  = 7'b0000001;
    localparam logic [6:0] C_MULN = 7'b0000011;
    localparam logic [6:0] C_NXM  = 7'b0100001;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   done = 0;

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         pzr = 1'b0;
    logic         png = 1'b0;
    logic [W-1:0] pout = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d",
                     name, act, req, cyc);
        end
    endtask

    // Drive a request until accepted; returns just after the accept edge.
    task automatic send(logic [W-1:0] xv, logic [W-1:0] yv,
                        logic [6:0] c, logic [W-1:0] ev,
                        int lat, bit expect_it);
        int   n;
        exp_t e;
        n = 0;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no, mul} = c;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else if (expect_it) begin
            e.out  = ev;
            e.zr   = (ev == '0);
            e.ng   = ev[W-1];
            e.when = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int   n;
        bit   fresh;
        exp_t e;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        {zx, nx, zy, ny, f, no, mul} = 7'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_zr", zr, 1);
        chk("rst_ng", ng, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;

        fork
            begin
                send(16'd5, 16'd3, C_ADD, 16'd8, 1, 1);
                send(16'd3, 16'd5, C_SUB, 16'hFFFE, 1, 1);
                send(16'd5, 16'd3, C_ZERO, 16'h0000, 1, 1);
                send(16'hF0F0, 16'h3C3C, C_AND, 16'h3030, 1, 1);
                send(16'h7FFF, 16'h0001, C_ADD, 16'h8000, 1, 1);
                send(16'hFFFF, 16'h0001, C_ADD, 16'h0000, 1, 1);

                send(16'd300, 16'd300, C_MUL, 16'h5F90, 17, 1);
                out_ready = 1'b0;
                x = 16'd1234;
                y = 16'd99;
                {zx, nx, zy, ny, f, no, mul} = C_ADD;
                in_valid = 1'b1;
                for (int i = 1; i <= 16; i++) begin
                    @(negedge clock);
                    chk("mul_busy_in_ready", in_ready, 0);
                    @(posedge clock);
                    #1;
                end
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_in_ready", in_ready, 0);
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
                send(16'd7, 16'd7, C_ADD, 16'd14, 1, 1);
                send(16'd7, 16'd9, C_MUL, 16'd63, 17, 1);
                send(16'd2, 16'd3, C_MULN, 16'hFFF9, 17, 1);
                send(16'd1, 16'd3, C_NXM, 16'hFFFA, 17, 1);
                send(16'd0, 16'd1234, C_MUL, 16'h0000, 17, 1);

                send(16'd300, 16'd300, C_MUL, 16'h0000, 17, 0);
                repeat (7) begin
                    @(posedge clock);
                    #1;
                end
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                @(negedge clock);
                chk("mulrst_out_valid", out_valid, 0);
                chk("mulrst_out", out, 0);
                chk("mulrst_zr", zr, 1);
                chk("mulrst_in_ready", in_ready, 1);
                repeat (30) @(posedge clock);
                #1;
                send(16'd5, 16'd3, C_ADD, 16'd8, 1, 1);

                n = 0;
                while (sb.size() > 0 && n < 100) begin
                    @(posedge clock);
                    n++;
                end
                if (sb.size() > 0) begin
                    checks++;
                    failures++;
                    $display("FAIL drain actual=%0d required=0",
                             sb.size());
                end
                @(posedge clock);
                #1;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clock);
                    if (done) break;
                    if (reset) begin
                        pv = 1'b0;
                        pr = 1'b0;
                        continue;
                    end
                    fresh = out_valid && !(pv && !pr);
                    if (fresh) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_result actual=%0h required=none",
                                     out);
                        end else begin
                            e = sb.pop_front();
                            chk("out", out, e.out);
                            chk("zr", zr, e.zr);
                            chk("ng", ng, e.ng);
                            chk("latency_cycle", cyc, e.when);
                        end
                    end
                    if (out_valid && pv && !pr) begin
                        chk("hold_out", out, pout);
                        chk("hold_zr", zr, pzr);
                        chk("hold_ng", ng, png);
                    end
                    if (out_valid && !out_ready) begin
                        chk("done_stall_in_ready", in_ready, 0);
                    end
                    pv   = out_valid;
                    pr   = out_ready;
                    pout = out;
                    pzr  = zr;
                    png  = ng;
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits, legal range 2..64.
REQ-002 SHALL have parameter MUL_EN, default 1; when 0, mul is ignored and treated as 0.
REQ-003 SHALL have port clock, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, request present.
REQ-006 SHALL have port in_ready, output, 1 bit, block can accept a request.
REQ-007 SHALL have ports x and y, input, WIDTH bits each, operands.
REQ-008 SHALL have ports zx, nx, zy, ny, f and no, input, 1 bit each, Hack ALU control bits.
REQ-009 SHALL have port mul, input, 1 bit, selects multiply in place of the f-selected op.
REQ-010 SHALL have port out_valid, output, 1 bit, result present.
REQ-011 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-012 SHALL have port out, output, WIDTH bits, result.
REQ-013 SHALL have ports zr and ng, output, 1 bit each, zero and negative flags of out.

Function
REQ-014 SHALL accept a request in a cycle where in_valid and in_ready are both 1, capturing x, y and all control bits.
REQ-015 SHALL preprocess operands: x2 = nx ? ~(zx ? 0 : x) : (zx ? 0 : x), and y2 likewise with zy and ny.
REQ-016 SHALL compute r = mul ? (x2*y2) mod 2^WIDTH : (f ? (x2+y2) mod 2^WIDTH : x2&y2), then out = no ? ~r : r.
REQ-017 SHALL set zr = (out == 0) and ng = out[WIDTH-1], both registered together with out.
REQ-018 SHALL implement the FSM states IDLE, MUL and DONE.
REQ-019 SHALL, in IDLE, drive in_ready=1; on accept with mul=0 it SHALL register the result and go to DONE, so out_valid rises 1 cycle after accept.
REQ-020 SHALL, in IDLE on accept with mul=1, load the multiplicand, multiplier, accumulator=0 and count=0, then go to MUL.
REQ-021 SHALL, in MUL, perform one shift-add step per cycle, keeping the accumulator WIDTH bits wide (mod 2^WIDTH), and move to DONE after WIDTH steps with no and the flags applied on entry.
REQ-022 SHALL give multiply a latency of WIDTH+1 cycles from accept to out_valid.
REQ-023 SHALL, in DONE, drive out_valid=1 and hold out, zr and ng stable while out_ready=0.
REQ-024 SHALL, in DONE with out_ready=1, drive in_ready=1 so that a simultaneous new accept is taken back-to-back: the next state is DONE (mul=0) or MUL (mul=1), with no bubble.
REQ-025 SHALL, in DONE with out_ready=1 and no accept, return to IDLE.
REQ-026 SHALL drive in_ready=0 throughout MUL.
REQ-027 SHALL ignore in_valid when in_ready=0 and SHALL NOT use the operand inputs after the accept cycle.
REQ-028 SHALL discard all arithmetic carries beyond WIDTH; there are no overflow outputs.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, set the state to IDLE, out=0, zr=1, ng=0, out_valid=0, and clear the counter and accumulator.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL give reset priority over every other event, including mid-MUL and DONE with out_ready=1; an in-flight operation is dropped and produces no output.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE/MUL/DONE) and the default width constant in a shared package, seq_alu_pkg.
REQ-033 SHALL implement the combinational preprocess/add/and/negate path as the sub-module alu_core, parametrised by WIDTH and reused for the mul=0 path and for the final no step.
REQ-034 SHALL keep the multiply step counter sized $clog2(WIDTH)+1 bits.

Verification
REQ-035 SHALL cover: WIDTH=16, x=5, y=3, f=1, other controls 0 -> out=8, zr=0, ng=0, out_valid 1 cycle after accept.
REQ-036 SHALL cover: x=3, y=5, nx=1, f=1, no=1 (x-y) -> out=0xFFFE, ng=1, zr=0.
REQ-037 SHALL cover: zx=1, zy=1, f=1, no=0 -> out=0, zr=1, ng=0.
REQ-038 SHALL cover: mul=1, x=300, y=300 -> out=0x5F90, with out_valid exactly 17 cycles after accept and in_ready=0 for cycles 1..16.
REQ-039 SHALL cover: out_ready held at 0 for 3 cycles in DONE -> out, zr and ng unchanged and in_ready=0; then out_ready=1 together with a new in_valid -> back-to-back accept.
REQ-040 SHALL cover: reset asserted at MUL step 7 -> next cycle out_valid=0, out=0, zr=1, in_ready=1, and no result from the dropped multiply ever appears.
